aes_key_scheduler: RTL

// - Sequential AES-128 key schedule. Iterates a one-round key-expansion step once per clock, 10 times.
// - Stores round keys 0..10 in an on-chip register file.
// - Sits between the key-load interface and the cipher round datapath.
// - The cipher reads the stored round keys by index, or consumes the streaming output as each key is produced.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_key_scheduler_if.sv | 28 ++
 rtl/aes_key_step.sv | 28 ++
 rtl/aes_key_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM state type, round-constant and S-box helpers.
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int RK_AW  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_key_scheduler_if.sv
// Key-load, streaming round-key and read-port signals between the key scheduler and the cipher.
interface aes_key_scheduler_if;
  import aes_pkg::*;

  // key_load is a request accepted only on an edge where busy==0; a request while busy
  // is dropped. rk_out_valid has no ready: the consumer must take each key the cycle it appears.
  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic             busy;
  logic             keys_ready;
  logic             done;
  logic             rk_out_valid;
  logic [RK_AW-1:0] rk_out_round;
  logic [KEY_W-1:0] rk_out_data;
  logic [RK_AW-1:0] rk_rd_addr;
  logic [KEY_W-1:0] rk_rd_data;
  state_t           dbg_state;

  modport master (
    output key_in, key_load, rk_rd_addr,
    input  busy, keys_ready, done, rk_out_valid, rk_out_round, rk_out_data, rk_rd_data, dbg_state
  );

  modport slave (
    input  key_in, key_load, rk_rd_addr,
    output busy, keys_ready, done, rk_out_valid, rk_out_round, rk_out_data, rk_rd_data, dbg_state
  );
endinterface

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion round: previous round key and rcon byte in, next key out.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_prev,
  input  logic [7:0]       rcon_byte,
  output logic [KEY_W-1:0] key_next
);
  logic [WORD_W-1:0] w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0] w_rot, w_sub, w_t;
  logic [WORD_W-1:0] w_o0, w_o1, w_o2, w_o3;

  assign w_w0 = key_prev[127:96];
  assign w_w1 = key_prev[95:64];
  assign w_w2 = key_prev[63:32];
  assign w_w3 = key_prev[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_t   = w_sub ^ {rcon_byte, 24'h000000};

  assign w_o0 = w_w0 ^ w_t;
  assign w_o1 = w_o0 ^ w_w1;
  assign w_o2 = w_o1 ^ w_w2;
  assign w_o3 = w_o2 ^ w_w3;

  assign key_next = {w_o0, w_o1, w_o2, w_o3};
endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key schedule: one expansion round per clock, round keys 0..10 kept in a
// register file with an indexed read port and streamed out as they are produced.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter bit RD_REG = 1'b0
) (
  input logic                clk,
  input logic                reset,
  aes_key_scheduler_if.slave bus
);
  state_t           r_state;
  logic [3:0]       r_round_cnt;
  logic [KEY_W-1:0] r_slots [0:AES_NR];
  logic             r_busy;
  logic             r_keys_ready;
  logic             r_done;
  logic             r_rk_out_valid;
  logic [3:0]       r_rk_out_round;
  logic [KEY_W-1:0] r_rk_out_data;
  logic [KEY_W-1:0] w_key_next;
  logic [KEY_W-1:0] w_rd_data;

  // During EXPAND the streaming register always holds round key k-1, so it feeds the step directly.
  aes_key_step u_step (
    .key_prev  (r_rk_out_data),
    .rcon_byte (rcon(r_round_cnt)),
    .key_next  (w_key_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_round_cnt    <= '0;
      r_busy         <= 1'b0;
      r_keys_ready   <= 1'b0;
      r_done         <= 1'b0;
      r_rk_out_valid <= 1'b0;
      r_rk_out_round <= '0;
      r_rk_out_data  <= '0;
      for (int i = 0; i <= AES_NR; i++) r_slots[i] <= '0;
    end else begin
      r_done         <= 1'b0;
      r_rk_out_valid <= 1'b0;
      case (r_state)
        IDLE, READY: begin
          if (bus.key_load) begin
            r_slots[0]     <= bus.key_in;
            r_rk_out_valid <= 1'b1;
            r_rk_out_round <= 4'd0;
            r_rk_out_data  <= bus.key_in;
            r_round_cnt    <= 4'd1;
            r_busy         <= 1'b1;
            r_keys_ready   <= 1'b0;
            r_state        <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= AES_NR; i++) begin
            if (4'(i) == r_round_cnt) r_slots[i] <= w_key_next;
          end
          r_rk_out_valid <= 1'b1;
          r_rk_out_round <= r_round_cnt;
          r_rk_out_data  <= w_key_next;
          if (r_round_cnt == 4'(NR)) begin
            // Counter parks at 0 so it never leaves the 0..10 range.
            r_round_cnt  <= 4'd0;
            r_done       <= 1'b1;
            r_keys_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= READY;
          end else begin
            r_round_cnt <= r_round_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i <= AES_NR; i++) begin
      if (bus.rk_rd_addr == 4'(i)) w_rd_data = r_slots[i];
    end
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic [KEY_W-1:0] r_rd_data;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= w_rd_data;
      end
      assign bus.rk_rd_data = r_rd_data;
    end else begin : g_rd_comb
      assign bus.rk_rd_data = w_rd_data;
    end
  endgenerate

  assign bus.busy         = r_busy;
  assign bus.keys_ready   = r_keys_ready;
  assign bus.done         = r_done;
  assign bus.rk_out_valid = r_rk_out_valid;
  assign bus.rk_out_round = r_rk_out_round;
  assign bus.rk_out_data  = r_rk_out_data;
  assign bus.dbg_state    = r_state;
endmodule
